// File: rtl/seq_multi_adder.sv
// Time-multiplexed multi-operand adder: sums NUM_OPS operands, one per cycle, behind
// valid/ready handshakes, with signed/unsigned, wrap/saturate and accumulate modes.
module seq_multi_adder #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_OPS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     IN_valid,
  output logic                     OUT_ready,
  input  logic [NUM_OPS*WIDTH-1:0] IN_ops,
  input  logic                     IN_signed,
  input  logic                     IN_sat,
  input  logic                     IN_acc,
  output logic                     OUT_valid,
  input  logic                     IN_ready,
  output logic [WIDTH-1:0]         OUT_sum,
  output logic                     OUT_ovf
);

  localparam int unsigned AccW = WIDTH + $clog2(NUM_OPS + 1) + 1;
  localparam int unsigned ExtW = AccW - WIDTH;
  localparam int unsigned CntW = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(NUM_OPS - 1);

  localparam logic signed [AccW-1:0] UMax = {{ExtW{1'b0}}, {WIDTH{1'b1}}};
  localparam logic signed [AccW-1:0] SMax = {{(ExtW + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [AccW-1:0] SMin = {{(ExtW + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StSum, StDone} state_e;

  state_e                     state_q, state_d;
  logic                       ready_q, ready_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [NUM_OPS*WIDTH-1:0]   ops_q, ops_d;
  logic                       signed_q, signed_d;
  logic                       sat_q, sat_d;
  logic signed [AccW-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]           sum_q, sum_d;
  logic                       ovf_q, ovf_d;
  logic [WIDTH-1:0]           last_q, last_d;

  logic [WIDTH-1:0]           op_sel;
  logic signed [AccW-1:0]     acc_next;
  logic                       above_hi;
  logic                       below_lo;
  logic [WIDTH-1:0]           sat_val;

  function automatic logic signed [AccW-1:0] ext(input logic [WIDTH-1:0] v, input logic sgn);
    ext = sgn ? {{ExtW{v[WIDTH-1]}}, v} : {{ExtW{1'b0}}, v};
  endfunction

  // Operand mux, written with constant part-selects.
  always_comb begin
    op_sel = '0;
    for (int unsigned i = 0; i < NUM_OPS; i++) begin
      if (cnt_q == CntW'(i)) op_sel = ops_q[i*WIDTH +: WIDTH];
    end
  end

  // The accumulator is wide enough that range checks on it are exact.
  always_comb begin
    acc_next = acc_q + ext(op_sel, signed_q);
    above_hi = signed_q ? (acc_next > SMax) : (acc_next > UMax);
    below_lo = signed_q ? (acc_next < SMin) : acc_next[AccW-1];
    if (above_hi) begin
      sat_val = signed_q ? {1'b0, {(WIDTH - 1){1'b1}}} : {WIDTH{1'b1}};
    end else if (below_lo) begin
      sat_val = signed_q ? {1'b1, {(WIDTH - 1){1'b0}}} : '0;
    end else begin
      sat_val = acc_next[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ops_d    = ops_q;
    signed_d = signed_q;
    sat_d    = sat_q;
    acc_d    = acc_q;
    sum_d    = sum_q;
    ovf_d    = ovf_q;
    last_d   = last_q;
    unique case (state_q)
      StIdle: begin
        if (IN_valid && ready_q) begin
          ops_d    = IN_ops;
          signed_d = IN_signed;
          sat_d    = IN_sat;
          acc_d    = IN_acc ? ext(last_q, IN_signed) : '0;
          cnt_d    = '0;
          state_d  = StSum;
        end
      end
      StSum: begin
        acc_d = acc_next;
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          ovf_d   = above_hi | below_lo;
          sum_d   = sat_q ? sat_val : acc_next[WIDTH-1:0];
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (IN_ready) begin
          last_d  = sum_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Registered so ready stays low during reset and for the cycle of the result handshake.
    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ready_q  <= 1'b0;
      cnt_q    <= '0;
      ops_q    <= '0;
      signed_q <= 1'b0;
      sat_q    <= 1'b0;
      acc_q    <= '0;
      sum_q    <= '0;
      ovf_q    <= 1'b0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      cnt_q    <= cnt_d;
      ops_q    <= ops_d;
      signed_q <= signed_d;
      sat_q    <= sat_d;
      acc_q    <= acc_d;
      sum_q    <= sum_d;
      ovf_q    <= ovf_d;
      last_q   <= last_d;
    end
  end

  assign OUT_ready = ready_q;
  assign OUT_valid = (state_q == StDone);
  assign OUT_sum   = sum_q;
  assign OUT_ovf   = ovf_q;

endmodule

// File: tb/tb_seq_multi_adder.sv
// Scoreboard bench for seq_multi_adder (WIDTH=8, NUM_OPS=4): directed bundles push expected
// results; a monitor pops and compares on every result handshake.
module tb_seq_multi_adder;

  localparam int W = 8;
  localparam int N = 4;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         ovf;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic [N*W-1:0] in_ops = '0;
  logic           in_signed = 1'b0;
  logic           in_sat = 1'b0;
  logic           in_acc = 1'b0;
  logic           in_ready = 1'b1;
  logic           out_ready;
  logic           out_valid;
  logic [W-1:0]   out_sum;
  logic           out_ovf;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  seq_multi_adder #(.WIDTH(W), .NUM_OPS(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .IN_valid (in_valid),
    .OUT_ready(out_ready),
    .IN_ops   (in_ops),
    .IN_signed(in_signed),
    .IN_sat   (in_sat),
    .IN_acc   (in_acc),
    .OUT_valid(out_valid),
    .IN_ready (in_ready),
    .OUT_sum  (out_sum),
    .OUT_ovf  (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each accepted result against the head of the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && in_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got sum %0h with empty scoreboard at %0t", out_sum, $time);
        end else begin
          e = sb_q.pop_front();
          check("sb_sum", 32'(out_sum), 32'(e.sum));
          check("sb_ovf", 32'(out_ovf), 32'(e.ovf));
        end
      end
    end
  end

  // Present a bundle until accepted; afterwards scramble inputs to prove they were captured.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic [7:0] d, input logic sgn, input logic sat, input logic acc,
                      input logic expect_out, input logic [7:0] es, input logic eo);
    int   k;
    exp_t e;
    in_ops    = {d, c, b, a};
    in_signed = sgn;
    in_sat    = sat;
    in_acc    = acc;
    in_valid  = 1'b1;
    k = 0;
    while (!out_ready && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready=0 expected ready=1 within 200 cycles");
    end
    if (expect_out) begin
      e.sum = es;
      e.ovf = eo;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_ops    = ~in_ops;
    in_signed = ~sgn;
    in_sat    = ~sat;
    in_acc    = ~acc;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!out_ready && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 200) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got ready=0 expected ready=1 within 200 cycles");
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000ns");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int k;
    int extra;

    // Reset state
    #12;
    check("rst_ready", 32'(out_ready), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_sum", 32'(out_sum), 0);
    check("rst_ovf", 32'(out_ovf), 0);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", 32'(out_ready), 0);
    @(posedge clk);
    #1;
    check("ready_after_edge", 32'(out_ready), 1);

    // Unsigned wrap fresh, with latency and throughput timing
    in_ready = 1'b1;
    send(8'd10, 8'd20, 8'd30, 8'd40, 1'b0, 1'b0, 1'b0, 1'b1, 8'd100, 1'b0);
    for (int i = 1; i < N; i++) begin
      @(posedge clk);
      #1;
      check("lat_not_yet", 32'(out_valid), 0);
    end
    @(posedge clk);
    #1;
    check("lat_valid", 32'(out_valid), 1);
    check("done_not_ready", 32'(out_ready), 0);
    @(posedge clk);
    #1;
    check("post_valid", 32'(out_valid), 0);
    check("post_ready", 32'(out_ready), 1);

    // Unsigned overflow: wrap then saturate
    send(8'd200, 8'd100, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd44, 1'b1);
    send(8'd200, 8'd100, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd255, 1'b1);

    // Signed: saturate low, accumulate onto the clamped value, wrap, in-range
    send(8'h9C, 8'h9C, 8'h9C, 8'h9C, 1'b1, 1'b1, 1'b0, 1'b1, 8'h80, 1'b1);
    send(8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h81, 1'b0);
    send(8'h9C, 8'h9C, 8'h9C, 8'h9C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h70, 1'b1);
    send(8'hFF, 8'h01, 8'h7F, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h7F, 1'b0);

    // Accumulate vs fresh
    send(8'd10, 8'd20, 8'd30, 8'd40, 1'b0, 1'b0, 1'b0, 1'b1, 8'd100, 1'b0);
    send(8'd1, 8'd1, 8'd1, 8'd1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd104, 1'b0);
    send(8'd1, 8'd1, 8'd1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0);

    // Backpressure: result held, ready low, IN_valid pulses ignored
    wait_idle();
    in_ready = 1'b0;
    send(8'd5, 8'd6, 8'd7, 8'd8, 1'b0, 1'b0, 1'b0, 1'b1, 8'd26, 1'b0);
    k = 0;
    while (!out_valid && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("bp_valid_seen", 32'(out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", 32'(out_valid && out_sum == 8'd26 && !out_ready), 1);
      in_ops   = {8'd1, 8'd1, 8'd1, 8'd1};
      in_valid = (i % 2 == 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", 32'(out_valid), 0);
    extra = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) extra++;
    end
    check("bp_no_extra", 32'(extra), 0);

    // Async reset during SUM cycle 2 clears the held result and last_result
    send(8'd9, 8'd9, 8'd9, 8'd9, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    @(posedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_ready", 32'(out_ready), 0);
    check("arst_sum", 32'(out_sum), 0);
    check("arst_ovf", 32'(out_ovf), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_ready_back", 32'(out_ready), 1);
    send(8'd1, 8'd2, 8'd3, 8'd4, 1'b0, 1'b0, 1'b1, 1'b1, 8'd10, 1'b0);

    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", 32'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
